// File: rtl/spi_cmd_ram.sv
// Command-decoding single-port RAM behind the SPI slave: din[9:8] selects write-addr,
// write-data, read-addr or read-data. Optional macro ADDR_AUTOINC_EN adds address auto-increment.
module spi_cmd_ram #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid
);

  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

  logic [7:0]           mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic                 rx_valid_d;
  logic                 accept;
  cmd_t                 cmd;
  logic                 wr_in_range;
  logic                 rd_in_range;
  logic [7:0]           rd_data;

  always_comb begin
    accept      = rx_valid & ~rx_valid_d;
    cmd         = cmd_t'(din[9:8]);
    wr_in_range = 32'(wr_addr) < MEM_DEPTH;
    rd_in_range = 32'(rd_addr) < MEM_DEPTH;
    // Out-of-range reads return zero instead of aliasing onto a low word.
    rd_data     = rd_in_range ? mem[rd_addr[IDX_W-1:0]] : '0;
  end

`ifdef ADDR_AUTOINC_EN
  logic [ADDR_SIZE-1:0] wr_addr_inc;
  logic [ADDR_SIZE-1:0] rd_addr_inc;

  always_comb begin
    wr_addr_inc = (32'(wr_addr) + 32'd1 == MEM_DEPTH) ? '0 : wr_addr + ADDR_SIZE'(1);
    rd_addr_inc = (32'(rd_addr) + 32'd1 == MEM_DEPTH) ? '0 : rd_addr + ADDR_SIZE'(1);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_valid_d <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      dout       <= '0;
      tx_valid   <= 1'b0;
    end else begin
      rx_valid_d <= rx_valid;
      if (accept) begin
        tx_valid <= 1'b0;
        unique case (cmd)
          CMD_WR_ADDR: wr_addr <= din[ADDR_SIZE-1:0];
          CMD_WR_DATA: begin
`ifdef ADDR_AUTOINC_EN
            wr_addr <= wr_addr_inc;
`endif
          end
          CMD_RD_ADDR: rd_addr <= din[ADDR_SIZE-1:0];
          CMD_RD_DATA: begin
            dout     <= rd_data;
            tx_valid <= 1'b1;
`ifdef ADDR_AUTOINC_EN
            rd_addr  <= rd_addr_inc;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  // Array kept out of the reset block so its contents survive reset.
  always_ff @(posedge clk) begin
    if (rst_n && accept && (cmd == CMD_WR_DATA) && wr_in_range)
      mem[wr_addr[IDX_W-1:0]] <= din[7:0];
  end

endmodule

// File: tb/tb_spi_cmd_ram.sv
// Scoreboard bench for spi_cmd_ram (MEM_DEPTH=128) with a reference model of the command decoder.
module tb_spi_cmd_ram;

  localparam int DEPTH = 128;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;

  always #5 clk = ~clk;

  spi_cmd_ram #(.MEM_DEPTH(DEPTH), .ADDR_SIZE(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .dout(dout), .tx_valid(tx_valid)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         exp_q[$];
  int         mwa, mra, mdout;
  logic [7:0] m [DEPTH];
  bit         k [DEPTH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bump(input int a);
    return (a + 1 == DEPTH) ? 0 : (a + 1) % 256;
  endfunction

  // Reference model; read expectations go to the scoreboard (-1 = data unknown).
  task automatic model_cmd(input logic [9:0] w);
    int b;
    int e;
    b = int'(w[7:0]);
    case (w[9:8])
      2'b00: mwa = b;
      2'b01: begin
        if (mwa < DEPTH) begin
          m[mwa] = w[7:0];
          k[mwa] = 1'b1;
        end
`ifdef ADDR_AUTOINC_EN
        mwa = bump(mwa);
`endif
      end
      2'b10: mra = b;
      default: begin
        if (mra >= DEPTH) e = 0;
        else if (k[mra]) e = int'(m[mra]);
        else e = -1;
        exp_q.push_back(e);
        mdout = e;
`ifdef ADDR_AUTOINC_EN
        mra = bump(mra);
`endif
      end
    endcase
  endtask

  task automatic send(input logic [9:0] w, input int hold);
    @(negedge clk);
    din = w;
    rx_valid = 1'b1;
    model_cmd(w);
    @(posedge clk);
    #1;
    if (w[9:8] == 2'b11) begin
      int e;
      e = exp_q.pop_front();
      check_eq("rd_valid", 32'(tx_valid), 32'd1);
      if (e >= 0) check_eq("rd_data", 32'(dout), e);
    end else begin
      check_eq("tx_clear", 32'(tx_valid), 32'd0);
      if (mdout >= 0) check_eq("dout_hold", 32'(dout), mdout);
    end
    repeat (hold - 1) @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; din = '0;
    mwa = 0; mra = 0; mdout = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_dout", 32'(dout), 32'h00);
    check_eq("rst_txv", 32'(tx_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    send(10'h200, 1); send(10'h300, 1);
    send(10'h000, 1); send(10'h15A, 1);
    send(10'h003, 1); send(10'h133, 1);
    send(10'h010, 1); send(10'h111, 1);

    send(10'h045, 1); send(10'h1A5, 1); send(10'h245, 1); send(10'h300, 1);

    repeat (20) @(posedge clk);
    #1;
    check_eq("idle_txv", 32'(tx_valid), 32'd1);
    check_eq("idle_dout", 32'(dout), 32'hA5);
    send(10'h010, 1);

    send(10'h002, 1); send(10'h1FF, 5); send(10'h1C3, 1);
    send(10'h202, 1); send(10'h300, 1);
    send(10'h203, 1); send(10'h300, 1);

    send(10'h07F, 1); send(10'h1E7, 1); send(10'h27F, 1); send(10'h300, 1);

    send(10'h090, 1); send(10'h177, 1); send(10'h290, 1); send(10'h300, 1);
    send(10'h280, 1); send(10'h300, 1);

    for (int a = 0; a < DEPTH; a++) begin
      if (k[a]) begin
        send({2'b10, 8'(a)}, 1);
        send(10'h300, 1);
      end
    end

    send(10'h245, 1); send(10'h300, 1);
    @(negedge clk);
    rst_n = 1'b0; din = 10'h3C4; rx_valid = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_txv", 32'(tx_valid), 32'd0);
    check_eq("midrst_dout", 32'(dout), 32'h00);
    mwa = 0; mra = 0; mdout = 0;
    @(negedge clk);
    rst_n = 1'b1; rx_valid = 1'b0;
    @(posedge clk);
    send(10'h300, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
